store_narrow_queue: RTL and testbench

//  Memory-stage store path: narrows 32-bit register store data to byte/halfword/word, aligns
//  it onto 32-bit data-memory byte lanes with byte enables, and queues it toward data memory.

---
 rtl/store_pkg.sv | 13 +
 rtl/store_fifo.sv | 41 ++++
 rtl/store_narrow_queue.sv | 81 ++++++++
 tb/tb_store_narrow_queue.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/store_pkg.sv
// store_pkg: shared store-size encodings and the queued store entry layout.
package store_pkg;
   localparam int SQ_AW = 32;
   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;
   localparam logic [1:0] SZ_BAD  = 2'b11;
   typedef struct packed {
      logic [SQ_AW-1:2] addr;
      logic [31:0]      wdata;
      logic [3:0]       be;
   } store_entry_t;
endpackage

// File: rtl/store_fifo.sv
// store_fifo: synchronous FIFO of store entries; while empty the output shows the last popped head.
module store_fifo
   import store_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     i_push,
   input  logic                     i_pop,
   input  store_entry_t             i_din,
   output store_entry_t             o_dout,
   output logic [$clog2(DEPTH):0]   o_count
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   store_entry_t  r_mem [DEPTH];
   logic [PW-1:0] r_wr;
   logic [PW-1:0] r_rd;
   logic [CW-1:0] r_count;
   logic [PW-1:0] w_prev;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
         r_wr    <= '0;
         r_rd    <= '0;
         r_count <= '0;
      end else begin
         if (i_push) begin
            r_mem[r_wr] <= i_din;
            r_wr        <= r_wr + PW'(1);
         end
         if (i_pop) r_rd <= r_rd + PW'(1);
         r_count <= r_count + CW'(i_push) - CW'(i_pop);
      end
   end
   // Pointers wrap naturally because DEPTH is a power of two.
   assign w_prev  = r_rd - PW'(1);
   assign o_dout  = (r_count == '0) ? r_mem[w_prev] : r_mem[r_rd];
   assign o_count = r_count;
endmodule

// File: rtl/store_narrow_queue.sv
// store_narrow_queue: narrows/aligns register store data onto byte lanes and queues it to data memory.
// Optional discarded-bits check enabled by STORE_TRUNC_CHECK_EN.
module store_narrow_queue
   import store_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int AW    = SQ_AW
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [AW-1:0]            in_addr,
   input  logic [31:0]              in_data,
   input  logic [1:0]               in_size,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [AW-1:0]            out_addr,
   output logic [31:0]              out_wdata,
   output logic [3:0]               out_be,
   output logic                     misalign,
   output logic                     trunc_flag,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int CW = $clog2(DEPTH) + 1;
   logic         w_acc;
   logic         w_bad;
   logic         w_push;
   logic         w_pop;
   store_entry_t w_entry;
   store_entry_t w_head;
   logic         r_misalign;
   assign in_ready = (count != CW'(DEPTH));
   assign w_acc    = in_valid & in_ready;
   assign w_bad    = (in_size == SZ_BAD) |
                     ((in_size == SZ_HALF) & in_addr[0]) |
                     ((in_size == SZ_WORD) & (in_addr[1:0] != 2'b00));
   assign w_push   = w_acc & ~w_bad;
   assign w_pop    = out_valid & out_ready;
   always_comb begin
      w_entry       = '0;
      w_entry.addr  = in_addr[AW-1:2];
      w_entry.wdata = (in_size == SZ_BYTE) ? {4{in_data[7:0]}} :
                      (in_size == SZ_HALF) ? {2{in_data[15:0]}} : in_data;
      w_entry.be    = (in_size == SZ_BYTE) ? (4'b0001 << in_addr[1:0]) :
                      (in_size == SZ_HALF) ? (in_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
   end
   store_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_din   (w_entry),
      .o_dout  (w_head),
      .o_count (count)
   );
   assign out_valid = (count != '0);
   assign out_addr  = {w_head.addr, 2'b00};
   assign out_wdata = w_head.wdata;
   assign out_be    = out_valid ? w_head.be : 4'b0000;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_misalign <= 1'b0;
      else        r_misalign <= w_acc & w_bad;
   end
   assign misalign = r_misalign;
`ifdef STORE_TRUNC_CHECK_EN
   logic w_trunc;
   logic r_trunc;
   // Discarded bits are fine if they are a zero or sign extension of the narrow value.
   assign w_trunc = (in_size == SZ_BYTE) ? !((in_data[31:8] == '0) || (in_data[31:8] == {24{in_data[7]}})) :
                    (in_size == SZ_HALF) ? !((in_data[31:16] == '0) || (in_data[31:16] == {16{in_data[15]}})) :
                    1'b0;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_trunc <= 1'b0;
      else        r_trunc <= w_push & w_trunc;
   end
   assign trunc_flag = r_trunc;
`else
   assign trunc_flag = 1'b0;
`endif
endmodule

// File: tb/tb_store_narrow_queue.sv
// tb_store_narrow_queue: directed vectors with hand-computed expectations for store_narrow_queue.
module tb_store_narrow_queue;
   import store_pkg::*;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_addr = '0;
   logic [31:0] in_data = '0;
   logic [1:0]  in_size = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_addr;
   logic [31:0] out_wdata;
   logic [3:0]  out_be;
   logic        misalign;
   logic        trunc_flag;
   logic [2:0]  count;
   int          n_cmp = 0;
   int          n_err = 0;
`ifdef STORE_TRUNC_CHECK_EN
   localparam logic TEXP = 1'b1;
`else
   localparam logic TEXP = 1'b0;
`endif

   store_narrow_queue #(.DEPTH(4), .AW(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr), .in_data(in_data), .in_size(in_size),
      .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr), .out_wdata(out_wdata), .out_be(out_be),
      .misalign(misalign), .trunc_flag(trunc_flag), .count(count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic send(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
      in_valid = 1'b1;
      in_addr  = a;
      in_data  = d;
      in_size  = s;
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic pop_chk(input string tag, input logic [31:0] a, input logic [31:0] d);
      chk({tag, "_valid"}, 32'(out_valid), 32'd1);
      chk({tag, "_addr"}, out_addr, a);
      chk({tag, "_wdata"}, out_wdata, d);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   initial begin
      repeat (2) @(negedge clk);
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_ready", 32'(in_ready), 32'd1);
      chk("rst_addr", out_addr, 32'h0);
      chk("rst_wdata", out_wdata, 32'h0);
      chk("rst_be", 32'(out_be), 32'h0);
      chk("rst_mis", 32'(misalign), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      send(32'h1003, 32'h0000_00AB, SZ_BYTE);
      chk("b_valid", 32'(out_valid), 32'd1);
      chk("b_addr", out_addr, 32'h1000);
      chk("b_wdata", out_wdata, 32'hABAB_ABAB);
      chk("b_be", 32'(out_be), 32'h8);
      chk("b_mis", 32'(misalign), 32'd0);
      chk("b_trunc", 32'(trunc_flag), 32'd0);
      chk("b_count", 32'(count), 32'd1);
      pop_chk("b_pop", 32'h1000, 32'hABAB_ABAB);
      chk("empty_valid", 32'(out_valid), 32'd0);
      chk("empty_be", 32'(out_be), 32'h0);
      chk("empty_hold_addr", out_addr, 32'h1000);
      chk("empty_hold_wdata", out_wdata, 32'hABAB_ABAB);

      send(32'h2002, 32'h1234_BEEF, SZ_HALF);
      chk("h1_wdata", out_wdata, 32'hBEEF_BEEF);
      chk("h1_be", 32'(out_be), 32'hC);
      chk("h1_trunc", 32'(trunc_flag), 32'(TEXP));
      pop_chk("h1_pop", 32'h2000, 32'hBEEF_BEEF);
      chk("h1_trunc_pulse", 32'(trunc_flag), 32'd0);
      send(32'h2002, 32'hFFFF_BEEF, SZ_HALF);
      chk("h2_trunc", 32'(trunc_flag), 32'd0);
      pop_chk("h2_pop", 32'h2000, 32'hBEEF_BEEF);
      send(32'h2000, 32'h0000_1234, SZ_HALF);
      chk("h3_be", 32'(out_be), 32'h3);
      pop_chk("h3_pop", 32'h2000, 32'h1234_1234);

      send(32'h3001, 32'h5555_5555, SZ_WORD);
      chk("w_mis", 32'(misalign), 32'd1);
      chk("w_mis_count", 32'(count), 32'd0);
      chk("w_mis_valid", 32'(out_valid), 32'd0);
      @(negedge clk);
      chk("w_mis_pulse", 32'(misalign), 32'd0);
      send(32'h2001, 32'h0000_1111, SZ_HALF);
      chk("h_mis", 32'(misalign), 32'd1);
      send(32'h4000, 32'h0000_2222, SZ_BAD);
      chk("bad_mis", 32'(misalign), 32'd1);
      chk("bad_count", 32'(count), 32'd0);

      for (int i = 0; i < 4; i++) send(32'h100 + 32'(4 * i), 32'h1111_1111 * 32'(i + 1), SZ_WORD);
      chk("full_count", 32'(count), 32'd4);
      chk("full_ready", 32'(in_ready), 32'd0);
      in_valid = 1'b1;
      in_addr  = 32'h110;
      in_data  = 32'h5555_5555;
      in_size  = SZ_WORD;
      repeat (2) @(negedge clk);
      chk("held_count", 32'(count), 32'd4);
      chk("held_ready", 32'(in_ready), 32'd0);
      chk("held_head", out_wdata, 32'h1111_1111);
      out_ready = 1'b1;
      @(negedge clk);
      chk("nobypass_count", 32'(count), 32'd3);
      chk("nobypass_ready", 32'(in_ready), 32'd1);
      out_ready = 1'b0;
      @(negedge clk);
      in_valid = 1'b0;
      chk("refill_count", 32'(count), 32'd4);
      pop_chk("q_b", 32'h104, 32'h2222_2222);
      in_valid  = 1'b1;
      in_addr   = 32'h114;
      in_data   = 32'h6666_6666;
      chk("pp_head", out_wdata, 32'h3333_3333);
      out_ready = 1'b1;
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b0;
      chk("pp_count", 32'(count), 32'd3);
      pop_chk("q_d", 32'h10C, 32'h4444_4444);
      pop_chk("q_e", 32'h110, 32'h5555_5555);
      pop_chk("q_f", 32'h114, 32'h6666_6666);
      chk("drain_count", 32'(count), 32'd0);
      chk("drain_valid", 32'(out_valid), 32'd0);
      chk("drain_hold", out_addr, 32'h114);

      for (int i = 0; i < 3; i++) send(32'h500 + 32'(4 * i), 32'hA0 + 32'(i), SZ_WORD);
      chk("pre_rst_count", 32'(count), 32'd3);
      #2 rst_n = 1'b0;
      #1;
      chk("async_count", 32'(count), 32'd0);
      chk("async_valid", 32'(out_valid), 32'd0);
      chk("async_addr", out_addr, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      chk("post_rst_valid", 32'(out_valid), 32'd0);
      chk("post_rst_count", 32'(count), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
